// File: rtl/lane_merge_ctrl.sv
// Purpose : two-lane un-striping merge; buffers each lane in its own FIFO and drains them in strict order 0,1,0,1...
// Latency : a word pushed on edge N can be output on edge N+1 at the earliest (no bypass); data_out/valid_out are registered.
// Backpressure: pause_x asserts when FIFO x holds >= AF_THRESH words; pushing into a full FIFO without a same-edge pop is a sticky error.
//
// Ports:
//   clk_2f, reset_L          - block clock (rising edge) and asynchronous active-low reset
//   lane_x / valid_x         - per-lane input word and push strobe (x = 0,1)
//   data_out / valid_out     - merged output word and its "new word" strobe
//   pause_0 / pause_1        - per-lane almost-full, decoded from the registered counts
//   next_lane                - lane the next output word will be taken from
//   error / state            - sticky overflow flag; FSM state 00 IDLE, 01 ACTIVE, 10 ERROR
module lane_merge_ctrl #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] lane_1,
    input  logic              valid_1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              pause_0,
    output logic              pause_1,
    output logic              next_lane,
    output logic              error,
    output logic [1:0]        state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_THRESH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACTIVE = 2'b01,
        S_ERROR  = 2'b10
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_mem0 [DEPTH];
    logic [DATA_W-1:0]  r_mem1 [DEPTH];
    logic [PTR_W-1:0]   r_wp0, r_rp0, r_wp1, r_rp1;
    logic [CNT_W-1:0]   r_cnt0, r_cnt1;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_valid_out;
    logic               r_next_lane;
    logic               r_error;

    logic w_push0, w_push1, w_pop0, w_pop1, w_ovf;
    logic w_wr0, w_wr1, w_rd0, w_rd1;

    // In IDLE lane 1 is only accepted alongside the first lane-0 word, so the
    // stream always starts aligned on lane 0.
    assign w_push0 = valid_0 && (r_state == S_IDLE || r_state == S_ACTIVE);
    assign w_push1 = valid_1 && ((r_state == S_IDLE && valid_0) || r_state == S_ACTIVE);

    // Only the lane selected by next_lane may be popped, and only when non-empty.
    assign w_pop0 = (r_state == S_ACTIVE) && !r_next_lane && (r_cnt0 != '0);
    assign w_pop1 = (r_state == S_ACTIVE) &&  r_next_lane && (r_cnt1 != '0);

    // A same-edge pop frees the slot, so a push into a full FIFO is then legal.
    assign w_ovf = (r_state == S_ACTIVE) &&
                   ((w_push0 && r_cnt0 == C_DEPTH && !w_pop0) ||
                    (w_push1 && r_cnt1 == C_DEPTH && !w_pop1));

    // The overflow edge freezes everything: the offending word is dropped
    // and no other FIFO or output activity takes place.
    assign w_wr0 = w_push0 && !w_ovf;
    assign w_wr1 = w_push1 && !w_ovf;
    assign w_rd0 = w_pop0  && !w_ovf;
    assign w_rd1 = w_pop1  && !w_ovf;

    // Storage needs no reset: counts/pointers define which entries are live.
    always_ff @(posedge clk_2f) begin
        if (w_wr0) r_mem0[r_wp0] <= lane_0;
        if (w_wr1) r_mem1[r_wp1] <= lane_1;
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= S_IDLE;
            r_wp0       <= '0;
            r_rp0       <= '0;
            r_wp1       <= '0;
            r_rp1       <= '0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_next_lane <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:   if (valid_0) r_state <= S_ACTIVE;
                S_ACTIVE: if (w_ovf) begin
                              r_state <= S_ERROR;
                              r_error <= 1'b1;
                          end
                S_ERROR:  r_error <= 1'b1;
                default:  r_state <= S_IDLE;
            endcase

            r_valid_out <= w_rd0 || w_rd1;
            if (w_rd0)      r_data_out <= r_mem0[r_rp0];
            else if (w_rd1) r_data_out <= r_mem1[r_rp1];
            if (w_rd0 || w_rd1) r_next_lane <= ~r_next_lane;

            // Pointers wrap naturally since DEPTH is a power of two.
            if (w_wr0) r_wp0 <= r_wp0 + PTR_W'(1);
            if (w_wr1) r_wp1 <= r_wp1 + PTR_W'(1);
            if (w_rd0) r_rp0 <= r_rp0 + PTR_W'(1);
            if (w_rd1) r_rp1 <= r_rp1 + PTR_W'(1);

            case ({w_wr0, w_rd0})
                2'b10:   r_cnt0 <= r_cnt0 + CNT_W'(1);
                2'b01:   r_cnt0 <= r_cnt0 - CNT_W'(1);
                default: r_cnt0 <= r_cnt0;
            endcase
            case ({w_wr1, w_rd1})
                2'b10:   r_cnt1 <= r_cnt1 + CNT_W'(1);
                2'b01:   r_cnt1 <= r_cnt1 - CNT_W'(1);
                default: r_cnt1 <= r_cnt1;
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign next_lane = r_next_lane;
    assign error     = r_error;
    assign state     = r_state;
    assign pause_0   = (r_cnt0 >= C_AF);
    assign pause_1   = (r_cnt1 >= C_AF);

endmodule

// File: tb/tb_lane_merge_ctrl.sv
// Purpose : self-checking bench for lane_merge_ctrl against a queue-based reference model.
// Latency : model advanced on every rising edge, DUT sampled 1 time unit later.
// Backpressure: random stimulus mostly honours the model's pause, occasionally ignores it to reach overflow.
module tb_lane_merge_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic          clk_2f  = 1'b0;
    logic          reset_L = 1'b0;
    logic [DW-1:0] lane_0  = '0;
    logic          valid_0 = 1'b0;
    logic [DW-1:0] lane_1  = '0;
    logic          valid_1 = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out, pause_0, pause_1, next_lane, error;
    logic [1:0]    state;

    lane_merge_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk_2f   (clk_2f),
        .reset_L  (reset_L),
        .lane_0   (lane_0),
        .valid_0  (valid_0),
        .lane_1   (lane_1),
        .valid_1  (valid_1),
        .data_out (data_out),
        .valid_out(valid_out),
        .pause_0  (pause_0),
        .pause_1  (pause_1),
        .next_lane(next_lane),
        .error    (error),
        .state    (state)
    );

    always #5 clk_2f = ~clk_2f;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per lane plus a mode (0 idle, 1 active, 2 error).
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            m_mode;
    logic [DW-1:0] m_dout;
    bit            m_vout;
    bit            m_nxt;
    logic [DW-1:0] seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_mode = 0;
        m_dout = '0;
        m_vout = 1'b0;
        m_nxt  = 1'b0;
    endtask

    task automatic model_edge(input bit v0, input logic [DW-1:0] d0,
                              input bit v1, input logic [DW-1:0] d1);
        bit pop0, pop1, ovf;
        m_vout = 1'b0;
        if (m_mode == 2) return;
        if (m_mode == 0) begin
            if (v0) begin
                q0.push_back(d0);
                if (v1) q1.push_back(d1);
                m_mode = 1;
            end
            return;
        end
        pop0 = !m_nxt && q0.size() > 0;
        pop1 =  m_nxt && q1.size() > 0;
        ovf  = (v0 && q0.size() == DEPTH && !pop0) || (v1 && q1.size() == DEPTH && !pop1);
        if (ovf) begin
            m_mode = 2;
            return;
        end
        if (pop0) m_dout = q0.pop_front();
        if (pop1) m_dout = q1.pop_front();
        if (pop0 || pop1) begin
            m_vout = 1'b1;
            m_nxt  = !m_nxt;
        end
        if (v0) q0.push_back(d0);
        if (v1) q1.push_back(d1);
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".data_out"},  data_out,          m_dout);
        chk({ctx, ".valid_out"}, 32'(valid_out),    32'(m_vout));
        chk({ctx, ".next_lane"}, 32'(next_lane),    32'(m_nxt));
        chk({ctx, ".error"},     32'(error),        32'(m_mode == 2));
        chk({ctx, ".state"},     32'(state),        32'(m_mode));
        chk({ctx, ".pause_0"},   32'(pause_0),      32'(q0.size() >= AF));
        chk({ctx, ".pause_1"},   32'(pause_1),      32'(q1.size() >= AF));
    endtask

    task automatic step(input string ctx, input bit v0, input logic [DW-1:0] d0,
                        input bit v1, input logic [DW-1:0] d1);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
        @(posedge clk_2f);
        model_edge(v0, d0, v1, d1);
        #1;
        check_all(ctx);
        if (valid_out) seen.push_back(data_out);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string ctx);
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        @(negedge clk_2f);
        reset_L = 1'b0;
        model_reset();
        #1;
        check_all({ctx, ".rst"});
        @(negedge clk_2f);
        reset_L = 1'b1;
        seen.delete();
    endtask

    initial begin
        bit            rv0, rv1;
        logic [DW-1:0] rd0, rd1;

        model_reset();
        #2;
        check_all("por");

        // Reset then interleave
        do_reset("t1");
        step("t1", 1'b1, 32'h0000FFFF, 1'b1, 32'hFFFFFFFF);
        chk("t1.state_active", 32'(state), 32'd1);
        step("t1", 1'b1, 32'h00000000, 1'b1, 32'h0000FFFF);
        for (int i = 0; i < 4; i++) step("t1", 1'b0, '0, 1'b0, '0);
        chk("t1.n_out", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            chk("t1.w0", seen[0], 32'h0000FFFF);
            chk("t1.w1", seen[1], 32'hFFFFFFFF);
            chk("t1.w2", seen[2], 32'h00000000);
            chk("t1.w3", seen[3], 32'h0000FFFF);
        end

        // Alignment: lane 1 words in IDLE are discarded
        do_reset("t2");
        for (int i = 0; i < 3; i++) step("t2", 1'b0, '0, 1'b1, 32'hAAAAAAAA);
        chk("t2.still_idle", 32'(state), 32'd0);
        step("t2", 1'b1, 32'h11111111, 1'b0, '0);
        for (int i = 0; i < 3; i++) step("t2", 1'b0, '0, 1'b0, '0);
        chk("t2.n_out", 32'(seen.size()), 32'd1);
        if (seen.size() == 1) chk("t2.first", seen[0], 32'h11111111);
        chk("t2.nl_held", 32'(next_lane), 32'd1);

        // Order stall: lane 0 waits behind an empty lane 1
        do_reset("t3");
        step("t3", 1'b1, 32'h1, 1'b0, '0);
        step("t3", 1'b1, 32'h2, 1'b0, '0);
        step("t3", 1'b0, '0, 1'b0, '0);
        step("t3", 1'b0, '0, 1'b0, '0);
        chk("t3.stall_vout", 32'(valid_out), 32'd0);
        step("t3", 1'b0, '0, 1'b1, 32'h3);
        for (int i = 0; i < 3; i++) step("t3", 1'b0, '0, 1'b0, '0);
        chk("t3.n_out", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("t3.w0", seen[0], 32'h1);
            chk("t3.w1", seen[1], 32'h3);
            chk("t3.w2", seen[2], 32'h2);
        end

        // Pause and overflow: both lanes every cycle, pause ignored
        do_reset("t4");
        for (int i = 0; i < 10; i++) step("t4", 1'b1, $urandom, 1'b1, $urandom);
        chk("t4.error", 32'(error), 32'd1);
        chk("t4.state", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) step("t4", 1'b1, $urandom, 1'b0, '0);
        chk("t4.vout_err", 32'(valid_out), 32'd0);

        // Async reset mid-stream with two words held per lane
        do_reset("t5");
        for (int i = 0; i < 3; i++) step("t5", 1'b1, 32'hDEAD0000 + i, 1'b1, 32'hBEEF0000 + i);
        chk("t5.q0_two", 32'(q0.size()), 32'd2);
        do_reset("t5b");
        step("t5b", 1'b1, 32'h55550000, 1'b1, 32'h66660000);
        for (int i = 0; i < 4; i++) step("t5b", 1'b0, '0, 1'b0, '0);
        chk("t5b.n_out", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("t5b.w0", seen[0], 32'h55550000);
            chk("t5b.w1", seen[1], 32'h66660000);
        end

        // Random episodes
        for (int e = 0; e < 6; e++) begin
            do_reset("rnd");
            for (int c = 0; c < 80; c++) begin
                rv0 = ($urandom_range(0, 3) != 0) &&
                      (q0.size() < AF || $urandom_range(0, 15) == 0);
                rv1 = ($urandom_range(0, 3) != 0) &&
                      (q1.size() < AF || $urandom_range(0, 15) == 0);
                rd0 = $urandom;
                rd1 = $urandom;
                step("rnd", rv0, rd0, rv1, rd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
